// File: rtl/tc_rom_stream_pkg.sv
// Shared types and constants for the ROM word streamer.
package tc_rom_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SIZE_REQ  = 3'd1,
    ST_SIZE_WAIT = 3'd2,
    ST_STREAM    = 3'd3,
    ST_DRAIN     = 3'd4
  } state_e;

  localparam logic [63:0] SIZE_QUERY_ADDR = {64{1'b1}};
  localparam int unsigned WORD_BYTES      = 8;
  localparam int unsigned BYTES_W         = 4;

  // Valid bytes in the final word from the effective size modulo 8.
  function automatic logic [BYTES_W-1:0] tail_bytes(input logic [2:0] rem);
    return (rem == 3'd0) ? BYTES_W'(WORD_BYTES) : {1'b0, rem};
  endfunction

endpackage

// File: rtl/tc_stream_fifo.sv
// Synchronous word FIFO with occupancy count; head word is visible combinationally.
module tc_stream_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tc_rom_streamer.sv
// Queries file length from the ROM, then streams its words through a credit-limited FIFO.
// Optional: TC_ROM_STREAMER_ZERO_PAD_EN zeroes bytes past end of file in the last word.
module tc_rom_streamer
  import tc_rom_stream_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [63:0] MAX_BYTES = 64'd65536,
  parameter logic [63:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [63:0]        file_size,
  output logic               size_clamped,
  output logic               rom_en,
  output logic [63:0]        rom_address,
  input  logic [63:0]        rom_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_data,
  output logic [BYTES_W-1:0] out_bytes,
  output logic               out_last
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW+1:0] CREDIT = (AW+2)'(DEPTH);

  state_e        state;
  logic [63:0]   issue_ptr;
  logic [63:0]   words;
  logic [63:0]   issued;
  logic [63:0]   popped;
  logic [2:0]    tail_rem;
  logic          inflight;
  logic          issue;
  logic          pop;
  logic          fifo_empty;
  logic          is_last;
  logic [AW:0]   fifo_count;
  logic [AW+1:0] occupancy;
  logic [63:0]   head;
  logic          clamp;
  logic [63:0]   eff;
  logic [63:0]   words_calc;

  assign clamp      = rom_data > MAX_BYTES;
  assign eff        = clamp ? MAX_BYTES : rom_data;
  assign words_calc = (eff >> 3) + {63'd0, |eff[2:0]};

  // A same-cycle pop frees its slot before the requested word lands, so DEPTH=2 keeps full rate.
  assign occupancy = {1'b0, fifo_count} + {{(AW+1){1'b0}}, inflight} - {{(AW+1){1'b0}}, pop};
  assign issue     = (state == ST_STREAM) && (issued != words) && (occupancy < CREDIT);

  assign rom_en = (state == ST_SIZE_REQ) || issue;
  always_comb begin
    rom_address = '0;
    if (state == ST_SIZE_REQ) rom_address = SIZE_QUERY_ADDR;
    else if (issue)           rom_address = issue_ptr;
  end

  assign busy      = (state != ST_IDLE);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign is_last   = (popped == words - 64'd1);
  assign out_last  = out_valid && is_last;
  assign out_bytes = !out_valid ? '0 : (is_last ? tail_bytes(tail_rem) : BYTES_W'(WORD_BYTES));

  always_comb begin
    out_data = out_valid ? head : '0;
`ifdef TC_ROM_STREAMER_ZERO_PAD_EN
    for (int unsigned b = 0; b < WORD_BYTES; b++) begin
      if (BYTES_W'(b) >= out_bytes) out_data[8*b +: 8] = '0;
    end
`endif
  end

  tc_stream_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(64)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (rom_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      done         <= 1'b0;
      file_size    <= '0;
      size_clamped <= 1'b0;
      issue_ptr    <= '0;
      words        <= '0;
      issued       <= '0;
      popped       <= '0;
      tail_rem     <= '0;
      inflight     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        issue_ptr <= issue_ptr + 64'(WORD_BYTES);
        issued    <= issued + 64'd1;
      end
      if (pop) popped <= popped + 64'd1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_SIZE_REQ;
            size_clamped <= 1'b0;
          end
        end
        ST_SIZE_REQ: state <= ST_SIZE_WAIT;
        ST_SIZE_WAIT: begin
          file_size    <= rom_data;
          size_clamped <= clamp;
          words        <= words_calc;
          tail_rem     <= eff[2:0];
          issued       <= '0;
          popped       <= '0;
          issue_ptr    <= BASE_ADDR;
          if (eff == '0) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else begin
            state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (issue && (issued == words - 64'd1)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop && is_last) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
